l2_arbiter: RTL
===============

// Module: l2_arbiter
// PURPOSE
//  Shares the single L1-side port of the unified L2 cache between the D-cache (port 0, read/write)
//  and the I-cache (port 1, read-only). Selects one requester, forwards its request to L2, latches
//  it until L2 asserts ready, routes rdata/ready back, and holds the loser in stall.
//  Sits between the two L1 controllers and L2; L2 memory-side ports are untouched.
// PARAMETERS
//  ADDR_W  30   word/line address width (matches L2 addr)
//  DATA_W  128  line width (matches L2 rdata/wdata)
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  reset      in   1       synchronous, active-high
//  d_read     in   1       D-cache read request
//  d_write    in   1       D-cache write request
//  d_addr     in   ADDR_W  D-cache line address
//  d_wdata    in   DATA_W  D-cache write line
//  d_rdata    out  DATA_W  line to D-cache, valid when d_ready
//  d_ready    out  1       D-cache transaction complete this cycle
//  d_stall    out  1       D-cache must hold request
//  i_read     in   1       I-cache read request
//  i_addr     in   ADDR_W  I-cache line address
//  i_rdata    out  DATA_W  line to I-cache, valid when i_ready
//  i_ready    out  1       I-cache transaction complete this cycle
//  i_stall    out  1       I-cache must hold request
//  l2_read    out  1       request to L2
//  l2_write   out  1       request to L2
//  l2_addr    out  ADDR_W  to L2
//  l2_wdata   out  DATA_W  to L2
//  l2_rdata   in   DATA_W  from L2
//  l2_ready   in   1       from L2, one-cycle completion pulse
//  l2_stall   in   1       from L2; informational, completion keyed on l2_ready only
// BEHAVIOUR
//  - Reset: state=IDLE, last_grant=I (so D wins first tie), latched request cleared; all outputs 0.
//  - req_d = d_read|d_write; req_i = i_read. Outputs fully combinational from state + inputs.
//  - IDLE: winner chosen same cycle: only one requesting -> it; both -> port != last_grant.
//    Winner's read/write/addr/wdata driven to L2 combinationally (L2 hit completes in 1 cycle);
//    I-port drives l2_write=0, l2_wdata=0. Request captured into latch regs at posedge.
//    l2_ready=1 -> winner ready=1, rdata=l2_rdata, stay IDLE, last_grant<=winner.
//    l2_ready=0 -> BUSY_D/BUSY_I per winner.
//  - BUSY_x: L2 driven from latched copy only (requester input changes ignored).
//    l2_ready=1 -> x ready=1, rdata=l2_rdata, last_grant<=x, next IDLE. Else stay.
//  - No request in IDLE: l2_read=l2_write=0, l2_addr=0, no state change.
//  - x_stall = req_x & ~x_ready. x_rdata = x_ready ? l2_rdata : 0. ready never to non-granted port.
//  - Requester dropping request while BUSY on it: transaction still completes, ready pulse still
//    issued. Loser dropping request while waiting: no effect.
//  - d_read & d_write together: forwarded unchanged (L2 resolves).
//  - Minimum gap: BUSY completion -> IDLE next cycle -> next arbitration that cycle (0 bubbles).
//  - Reset mid-BUSY: IDLE next cycle, latch dropped; L2 resets on same edge.
// CONFIGURATION
//  L2ARB_DPRIO_EN defined: fixed priority, D always wins ties in IDLE; last_grant still tracked
//    but unused for selection.
//  Undefined (default): round-robin on ties as above; no starvation for either port.
// TESTING
//  1 Reset: reset=1 two cycles, both ports requesting -> all outputs 0, l2_read=0 throughout.
//  2 D hit: d_read=1, d_addr=30'h100, l2_ready=1 same cycle, l2_rdata=128'hA5.. -> d_ready=1,
//    d_rdata=128'hA5.., d_stall=0, i outputs 0, state stays IDLE.
//  3 Tie RR: both request addr 30'h40/30'h80, L2 ready 1 cycle each -> grants D,I,D,I on
//    successive cycles; with L2ARB_DPRIO_EN -> D every cycle, i_stall=1 throughout.
//  4 Miss hold: I granted, l2_ready low 5 cycles; I changes i_addr mid-wait -> l2_addr stays
//    original value, i_stall=1 for 5 cycles, i_ready pulse on cycle 6, d_stall=1 all 6 cycles.
//  5 Dirty write: d_write=1, d_wdata=128'h1234, l2_ready at cycle 3 -> l2_write=1 and
//    l2_wdata=128'h1234 for cycles 0-3, d_ready one cycle, then IDLE.
//  6 Reset in BUSY_D at cycle 2 -> cycle 3 IDLE, l2_read=l2_write=0, no d_ready issued.

Source files
------------

// File: rtl/l2_arbiter.sv
// Two-port arbiter sharing the L1-side L2 port between D-cache (port 0) and I-cache (port 1).
// Optional macro L2ARB_DPRIO_EN: fixed D-priority on ties instead of round-robin.
module l2_arbiter #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_stall,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  output logic              i_stall,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic [DATA_W-1:0] l2_rdata,
  input  logic              l2_ready,
  input  logic              l2_stall
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  state_t              state;
  logic                last_grant_i;
  logic                lat_read;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  logic req_d, req_i, d_wins_tie;
  logic grant_d, grant_i;
  logic serve_d, serve_i;
  logic unused_inputs;

  always_comb begin
    req_d      = d_read | d_write;
    req_i      = i_read;
`ifdef L2ARB_DPRIO_EN
    d_wins_tie    = 1'b1;
    unused_inputs = l2_stall ^ last_grant_i;
`else
    d_wins_tie    = last_grant_i;
    unused_inputs = l2_stall;
`endif
    grant_d    = req_d & (~req_i | d_wins_tie);
    grant_i    = req_i & ~grant_d;

    serve_d    = 1'b0;
    serve_i    = 1'b0;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_addr    = '0;
    l2_wdata   = '0;

    case (state)
      IDLE: begin
        if (grant_d) begin
          serve_d  = 1'b1;
          l2_read  = d_read;
          l2_write = d_write;
          l2_addr  = d_addr;
          l2_wdata = d_wdata;
        end else if (grant_i) begin
          serve_i  = 1'b1;
          l2_read  = 1'b1;
          l2_addr  = i_addr;
        end
      end
      BUSY_D, BUSY_I: begin
        serve_d  = (state == BUSY_D);
        serve_i  = (state == BUSY_I);
        l2_read  = lat_read;
        l2_write = lat_write;
        l2_addr  = lat_addr;
        l2_wdata = lat_wdata;
      end
      default: ;
    endcase

    // Outputs are forced quiet while reset is held, even though they are combinational.
    if (reset) begin
      serve_d  = 1'b0;
      serve_i  = 1'b0;
      l2_read  = 1'b0;
      l2_write = 1'b0;
      l2_addr  = '0;
      l2_wdata = '0;
    end

    d_ready = serve_d & l2_ready;
    i_ready = serve_i & l2_ready;
    d_rdata = d_ready ? l2_rdata : '0;
    i_rdata = i_ready ? l2_rdata : '0;
    d_stall = ~reset & req_d & ~d_ready;
    i_stall = ~reset & req_i & ~i_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant_i <= 1'b1;
      lat_read     <= 1'b0;
      lat_write    <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d | grant_i) begin
            lat_read  <= l2_read;
            lat_write <= l2_write;
            lat_addr  <= l2_addr;
            lat_wdata <= l2_wdata;
            if (l2_ready)
              last_grant_i <= grant_i;
            else
              state <= grant_d ? BUSY_D : BUSY_I;
          end
        end
        BUSY_D: begin
          if (l2_ready) begin
            last_grant_i <= 1'b0;
            state        <= IDLE;
          end
        end
        BUSY_I: begin
          if (l2_ready) begin
            last_grant_i <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
